div2_engine: RTL and testbench

- Hardware responder for the program-2 protocol: 16-bit dividend ÷ 8-bit divisor, producing a 24-bit quotient with 8 fractional bits.
- Driven by the same Start/Ack handshake and data-memory layout the CPU uses:
  - Reads operands from data memory at byte addresses 0,1,2.
  - Computes floor(dividend·256 / divisor) with a bit-serial restoring divider.
  - Writes result bytes to addresses 4,5,6 and raises Ack.
- Sits beside DM1 as a drop-in accelerator and golden model for the CPU's program 2.

---
 rtl/div2_engine_if.sv | 30 +++
 rtl/div2_engine.sv | 150 +++++++++++++++
 tb/tb_div2_engine.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/div2_engine_if.sv
// Start/Ack handshake and data-memory port shared by the CPU and div2_engine.
// slave = responder side (div2_engine), master = host/memory side.
interface div2_engine_if #(
  parameter int ADDR_W = 8
);
  logic              Start;
  logic              Ack;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemRdData;
  logic [7:0]        MemWrData;
  logic              MemWrEn;

  modport slave (
    input  Start,
    input  MemRdData,
    output Ack,
    output MemAddr,
    output MemWrData,
    output MemWrEn
  );

  modport master (
    output Start,
    output MemRdData,
    input  Ack,
    input  MemAddr,
    input  MemWrData,
    input  MemWrEn
  );
endinterface

// File: rtl/div2_engine.sv
// Program-2 accelerator: floor(dvd*256/divisor) via bit-serial restoring divide.
// Define DIV2_ROUND_EN for half-LSB upward rounding (25 iterations).
module div2_engine #(
  parameter int ADDR_W       = 8,
  parameter int OPND_HI_ADDR = 0,
  parameter int OPND_LO_ADDR = 1,
  parameter int DIVR_ADDR    = 2,
  parameter int RES_ADDR     = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  div2_engine_if.slave bus
);

`ifdef DIV2_ROUND_EN
  localparam int NB = 25;
`else
  localparam int NB = 24;
`endif
  localparam logic [4:0] LAST = 5'(NB - 1);

  localparam logic [ADDR_W-1:0] A_HI = ADDR_W'(OPND_HI_ADDR);
  localparam logic [ADDR_W-1:0] A_LO = ADDR_W'(OPND_LO_ADDR);
  localparam logic [ADDR_W-1:0] A_DV = ADDR_W'(DIVR_ADDR);
  localparam logic [ADDR_W-1:0] A_R0 = ADDR_W'(RES_ADDR);
  localparam logic [ADDR_W-1:0] A_R1 = ADDR_W'(RES_ADDR + 1);
  localparam logic [ADDR_W-1:0] A_R2 = ADDR_W'(RES_ADDR + 2);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, DIV, WR0, WR1, WR2, DONE
  } state_t;

  state_t        state;
  logic          start_q;
  logic [15:0]   dvd;
  logic [7:0]    divisor;
  logic [NB-1:0] n;
  logic [8:0]    rem;
  logic [NB-1:0] quot;
  logic [4:0]    count;

  logic [8:0]    rem_sh;
  logic          ge;
  logic [8:0]    rem_nx;
  logic [NB-1:0] q_nx;
  logic [23:0]   res;

  always_comb begin
    rem_sh = {rem[7:0], n[NB-1]};
    ge     = rem_sh >= {1'b0, divisor};
    rem_nx = ge ? rem_sh - {1'b0, divisor} : rem_sh;
    q_nx   = {quot[NB-2:0], ge};
`ifdef DIV2_ROUND_EN
    // rounding cannot wrap: a set half bit needs divisor>=2
    res    = q_nx[24:1] + 24'(q_nx[0]);
`else
    res    = q_nx;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      dvd           <= '0;
      divisor       <= '0;
      n             <= '0;
      rem           <= '0;
      quot          <= '0;
      count         <= '0;
      bus.Ack       <= 1'b0;
      bus.MemAddr   <= '0;
      bus.MemWrData <= '0;
      bus.MemWrEn   <= 1'b0;
    end else begin
      start_q <= bus.Start;
      case (state)
        IDLE: begin
          if (!bus.Start && start_q) begin
            bus.MemAddr <= A_HI;
            state       <= RD0;
          end
        end
        RD0: begin
          dvd[15:8]   <= bus.MemRdData;
          bus.MemAddr <= A_LO;
          state       <= RD1;
        end
        RD1: begin
          dvd[7:0]    <= bus.MemRdData;
          bus.MemAddr <= A_DV;
          state       <= RD2;
        end
        RD2: begin
          divisor <= bus.MemRdData;
          if (bus.MemRdData == 8'd0) begin
            quot          <= NB'(24'hFFFFFF);
            bus.MemWrEn   <= 1'b1;
            bus.MemAddr   <= A_R0;
            bus.MemWrData <= 8'hFF;
            state         <= WR0;
          end else begin
            n     <= {dvd, {(NB-16){1'b0}}};
            rem   <= '0;
            quot  <= '0;
            count <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          rem   <= rem_nx;
          n     <= n << 1;
          count <= count + 5'd1;
          if (count == LAST) begin
            quot          <= NB'(res);
            bus.MemWrEn   <= 1'b1;
            bus.MemAddr   <= A_R0;
            bus.MemWrData <= res[23:16];
            state         <= WR0;
          end else begin
            quot <= q_nx;
          end
        end
        WR0: begin
          bus.MemAddr   <= A_R1;
          bus.MemWrData <= quot[15:8];
          state         <= WR1;
        end
        WR1: begin
          bus.MemAddr   <= A_R2;
          bus.MemWrData <= quot[7:0];
          state         <= WR2;
        end
        WR2: begin
          bus.MemWrEn <= 1'b0;
          bus.Ack     <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.Start) begin
            bus.Ack <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div2_engine.sv
// Directed bench for div2_engine: results, latency, reset abort, handshake.
// Expectations follow DIV2_ROUND_EN when defined.
module tb_div2_engine;

`ifdef DIV2_ROUND_EN
  localparam int LAT = 31;
  localparam logic [23:0] R385 = 24'h00402B;
`else
  localparam int LAT = 30;
  localparam logic [23:0] R385 = 24'h00402A;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   miss = 0;
  int   wr_cnt = 0;
  int   w0;
  int   n;

  logic [7:0] op  [0:255];
  logic [7:0] res [0:255];

  div2_engine_if #(.ADDR_W(8)) bus();

  div2_engine dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.MemRdData = op[bus.MemAddr];

  always @(posedge clk) begin
    if (bus.MemWrEn) begin
      res[bus.MemAddr] <= bus.MemWrData;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [7:0] v);
    op[0] = d[15:8];
    op[1] = d[7:0];
    op[2] = v;
  endtask

  // returns just after the launch edge E0
  task automatic launch();
    @(negedge clk) bus.Start = 1'b1;
    @(negedge clk) bus.Start = 1'b0;
    w0 = wr_cnt;
    @(posedge clk);
  endtask

  task automatic wait_ack(inout int cnt);
    do begin
      @(posedge clk);
      cnt++;
      #1;
    end while (!bus.Ack && cnt < 100);
  endtask

  task automatic run(input string tag, input logic [15:0] d,
                     input logic [7:0] v, input logic [23:0] exp,
                     input int lat);
    int c;
    load(d, v);
    launch();
    c = 0;
    wait_ack(c);
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_res"}, {8'h00, res[4], res[5], res[6]}, {8'h00, exp});
    chk({tag, "_wr"}, wr_cnt - w0, 3);
  endtask

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", bus.Ack, 0);
    chk("rst_wren", bus.MemWrEn, 0);
    chk("rst_addr", bus.MemAddr, 0);
    chk("rst_wdata", bus.MemWrData, 0);
    rst = 1'b0;

    run("385_6", 16'd385, 8'd6, R385, LAT);
    run("3_255", 16'd3, 8'd255, 24'h000003, LAT);
    run("ffff_1", 16'hFFFF, 8'd1, 24'hFFFF00, LAT);
    run("ffff_255", 16'hFFFF, 8'd255, 24'h010100, LAT);
    run("1_2", 16'd1, 8'd2, 24'h000080, LAT);
    run("div0", 16'h1234, 8'd0, 24'hFFFFFF, 6);

    // reset sampled at E0+10 aborts the divide
    load(16'd385, 8'd6);
    launch();
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ack", bus.Ack, 0);
    chk("abort_wren", bus.MemWrEn, 0);
    @(negedge clk) rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_ack_late", bus.Ack, 0);
    chk("abort_nowr", wr_cnt - w0, 0);
    chk("abort_res", {8'h00, res[4], res[5], res[6]}, 32'h00FFFFFF);
    run("after_rst", 16'd385, 8'd6, R385, LAT);

    // Start pulse during DIV is ignored
    load(16'h0100, 8'd3);
    launch();
    n = 0;
    repeat (8) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk) bus.Start = 1'b1;
    @(posedge clk) n++;
    @(negedge clk);
    @(posedge clk) n++;
    @(negedge clk) bus.Start = 1'b0;
    wait_ack(n);
    chk("tog_lat", n, LAT);
    chk("tog_res", {8'h00, res[4], res[5], res[6]}, 32'h00005555);
    chk("tog_wr", wr_cnt - w0, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("done_hold", bus.Ack, 1);
    chk("done_nowr", wr_cnt - w0, 3);
    @(negedge clk) bus.Start = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_drop", bus.Ack, 0);

    run("1000_7", 16'd1000, 8'd7, 24'h008EDB, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
